alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised successor to the 8-bit accumulator-side ALU. It adds width generalisation, a status-flag register (Z/N/C/V), carry-chained and shift ops, and a compare op.
- Adds a multi-cycle shift-add multiplier with a ready/done handshake toward the IR/control sequencer.
- Keeps the internal operand register R, loaded from AC, and the same 4-bit operation encoding for codes 0-9.

Parameters:
- WIDTH, 8, datapath width of ac, R, alu_out (>=2).
- MUL_EN, 1, 1 = MUL implemented; 0 = MUL code decodes as NOP (single-cycle, no state change except done).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- en  input  1  issue strobe from IR; accepted only when ready=1.
- operation  input  4  opcode, sampled on accept.
- ac  input  WIDTH  accumulator operand, sampled on accept.
- alu_out  output  WIDTH  registered result.
- flag_z  output  1  result zero.
- flag_n  output  1  result MSB.
- flag_c  output  1  carry / borrow / shifted-out bit.
- flag_v  output  1  signed overflow.
- ready  output  1  1 = can accept an issue this cycle.
- done  output  1  one-cycle pulse; alu_out/flags valid from that cycle.

Behaviour:
- Reset (rst=1 at edge): alu_out=0, R=0, all flags=0, ready=1, done=0, FSM=IDLE. Reset overrides everything, including an in-flight MUL, which is aborted with no done.
- Accept = en & ready at a rising edge. en while ready=0 is ignored (not queued).
- FSM states:
  - IDLE: ready=1. Single-cycle op accepted -> result/flags written at that edge, done=1 the following cycle, stays IDLE (back-to-back issue each cycle allowed). MUL accepted -> latch ac, R into multiplier; ready=0; go BUSY, iteration counter=0.
  - BUSY: one shift-add step per edge over a 2*WIDTH accumulator. At the WIDTH-th edge after accept, write the low half to alu_out and flags, go IDLE; ready=1 and done=1 in the following cycle. Total latency is WIDTH cycles vs 1 for all other ops.
- Opcodes (result -> alu_out unless noted; s = result):
  - 0 MOVAC: R<=ac, s=ac; Z,N updated; C,V kept.
  - 1 MOVR: s=R; Z,N updated; C,V kept.
  - 2 ADD: s=ac+R; C=carry-out, V=signed overflow.
  - 3 SUB: s=ac-R; C=1 iff borrow (ac<R unsigned); V=signed overflow.
  - 4 INAC: s=ac+1; C,V as ADD with R=1.
  - 5 CLAC: s=0; Z=1, N=0; C,V kept.
  - 6 AND, 7 OR, 8 XOR (ac op R), 9 NOT (~ac): Z,N updated; C=0, V=0.
  - A ADC: s=ac+R+C; C,V as ADD.
  - B SHL: s=ac<<1; C=ac[MSB]; V=0.
  - C SHR (logical): s=ac>>1; C=ac[0]; V=0.
  - D CMP: flags as SUB; alu_out and R unchanged.
  - E MUL (unsigned): s=low WIDTH bits of ac*R; C=1 iff high half nonzero; V=0.
  - F NOP: no change; done still pulses.
- All arithmetic is modulo 2^WIDTH. Z and N are always derived from s, except under NOP, CMP (from the difference) and where kept.
- done never asserts without a preceding accept. Two done pulses never overlap.

Test Plan:
1. Reset: hold rst 2 cycles after random activity -> alu_out=0x00, flags=0000, ready=1, done=0. Then MOVR -> alu_out=0x00, Z=1.
2. Carry: MOVAC ac=0x05, then ADD ac=0xFF -> alu_out=0x04, C=1, Z=0, V=0, done 1 cycle after each issue. Then ADC ac=0x10 -> 0x16, C=0.
3. Overflow/borrow: MOVAC ac=0x01, SUB ac=0x80 -> 0x7F, V=1, C=0, N=0. CMP ac=0x00 -> alu_out stays 0x7F, C=1, N=1, Z=0.
4. Shifts/logic: SHL ac=0x81 -> 0x02, C=1. SHR ac=0x01 -> 0x00, Z=1, C=1. XOR (R=0x05) ac=0x05 -> 0x00, Z=1, C=0.
5. MUL: MOVAC 0x12, MUL ac=0x10 -> ready=0 for 8 cycles; en pulses during BUSY ignored; then alu_out=0x20, C=1, done one cycle, ready=1. MUL 0x03*0x05 -> 0x0F, C=0.
6. Reset mid-MUL: rst at 4th BUSY cycle -> next edge alu_out=0, ready=1, no done ever; subsequent ADD completes normally. With MUL_EN=0, opcode E -> done pulse, outputs unchanged.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - parametrised accumulator-side ALU with Z/N/C/V flags and multi-cycle shift-add MUL
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] ac,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             ready,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_MOVAC = 4'h0;
  localparam logic [3:0] OP_MOVR  = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_INAC  = 4'h4;
  localparam logic [3:0] OP_CLAC  = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_XOR   = 4'h8;
  localparam logic [3:0] OP_NOT   = 4'h9;
  localparam logic [3:0] OP_ADC   = 4'hA;
  localparam logic [3:0] OP_SHL   = 4'hB;
  localparam logic [3:0] OP_SHR   = 4'hC;
  localparam logic [3:0] OP_CMP   = 4'hD;
  localparam logic [3:0] OP_MUL   = 4'hE;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               accept;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH:0]     add_res;
  logic               add_v;
  logic [WIDTH:0]     sub_res;
  logic               sub_v;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   s;
  logic               wr_out;
  logic               upd_zn;

  assign accept = en && (state_q == S_IDLE);

  // One adder serves ADD, INAC (b=1) and ADC (carry-in from C)
  always_comb begin
    add_b   = (operation == OP_INAC) ? WIDTH'(1) : r_q;
    add_cin = (operation == OP_ADC) ? c_q : 1'b0;
    add_res = {1'b0, ac} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    add_v   = (ac[WIDTH-1] == add_b[WIDTH-1]) && (add_res[WIDTH-1] != ac[WIDTH-1]);
    sub_res = {1'b0, ac} - {1'b0, r_q};
    sub_v   = (ac[WIDTH-1] != r_q[WIDTH-1]) && (sub_res[WIDTH-1] != ac[WIDTH-1]);
  end

  // Shift-add step: upper half accumulates multiplicand, lower half holds remaining multiplier bits
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    r_d     = r_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;
    done_d  = 1'b0;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    s       = '0;
    wr_out  = 1'b0;
    upd_zn  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          done_d = 1'b1;
          case (operation)
            OP_MOVAC: begin r_d = ac; s = ac; wr_out = 1'b1; upd_zn = 1'b1; end
            OP_MOVR:  begin s = r_q; wr_out = 1'b1; upd_zn = 1'b1; end
            OP_ADD, OP_INAC, OP_ADC: begin
              s = add_res[WIDTH-1:0]; wr_out = 1'b1; upd_zn = 1'b1;
              c_d = add_res[WIDTH]; v_d = add_v;
            end
            OP_SUB: begin
              s = sub_res[WIDTH-1:0]; wr_out = 1'b1; upd_zn = 1'b1;
              c_d = sub_res[WIDTH]; v_d = sub_v;
            end
            OP_CLAC: begin s = '0; wr_out = 1'b1; upd_zn = 1'b1; end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
              case (operation)
                OP_AND:  s = ac & r_q;
                OP_OR:   s = ac | r_q;
                OP_XOR:  s = ac ^ r_q;
                default: s = ~ac;
              endcase
              wr_out = 1'b1; upd_zn = 1'b1; c_d = 1'b0; v_d = 1'b0;
            end
            OP_SHL: begin
              s = {ac[WIDTH-2:0], 1'b0}; wr_out = 1'b1; upd_zn = 1'b1;
              c_d = ac[WIDTH-1]; v_d = 1'b0;
            end
            OP_SHR: begin
              s = {1'b0, ac[WIDTH-1:1]}; wr_out = 1'b1; upd_zn = 1'b1;
              c_d = ac[0]; v_d = 1'b0;
            end
            // Flags from the difference, result register left alone
            OP_CMP: begin
              s = sub_res[WIDTH-1:0]; upd_zn = 1'b1;
              c_d = sub_res[WIDTH]; v_d = sub_v;
            end
            OP_MUL: begin
              if (MUL_EN) begin
                done_d  = 1'b0;
                mcand_d = ac;
                acc_d   = {{WIDTH{1'b0}}, r_q};
                cnt_d   = '0;
                state_d = S_BUSY;
              end
            end
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          s       = mul_next[WIDTH-1:0];
          wr_out  = 1'b1;
          upd_zn  = 1'b1;
          c_d     = |mul_next[2*WIDTH-1:WIDTH];
          v_d     = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_out) out_d = s;
    if (upd_zn) begin
      z_d = (s == '0);
      n_d = s[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      r_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      r_q     <= r_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      done_q  <= done_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_out = out_q;
  assign flag_z  = z_q;
  assign flag_n  = n_q;
  assign flag_c  = c_q;
  assign flag_v  = v_q;
  assign ready   = (state_q == S_IDLE);
  assign done    = done_q;

endmodule
